beta_cmp_seq: RTL

- Parametrised, sequential successor to the Beta compare unit.
- Computes its own compare result from two operands instead of consuming ALU flags. Scans operands MSB-first in SLICE-bit chunks, with early termination on the first differing slice.
- Adds unsigned compares (CMPLTU, CMPLEU) and a valid/ready handshake on both sides.
- Sits beside the ALU in the execute stage; the result is zero-extended to WIDTH bits for register writeback.

---
 rtl/beta_cmp_seq_if.sv | 25 ++
 rtl/beta_cmp_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/beta_cmp_seq_if.sv
// Request/response handshake bundle for the sequential compare unit.
// The requester uses the master modport, the compare unit uses slave.
interface beta_cmp_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/beta_cmp_seq.sv
// Sequential Beta compare unit: MSB-first slice scan with early exit,
// signed/unsigned compares and valid/ready handshakes on both sides.
module beta_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic clk,
    input  logic reset,
    beta_cmp_seq_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] TOP = IW'(N - 1);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_LT  = 3'b001;
    localparam logic [2:0] OP_LE  = 3'b010;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_LEU = 3'b101;

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("beta_cmp_seq: SLICE must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             res_q, res_d;

    logic [SLICE-1:0] sa, sb;
    logic             slice_lt, slice_eq;

    function automatic logic op_valid(input logic [2:0] o);
        return (o == OP_EQ) || (o == OP_LT) || (o == OP_LE) ||
               (o == OP_LTU) || (o == OP_LEU);
    endfunction

    function automatic logic op_signed(input logic [2:0] o);
        return (o == OP_LT) || (o == OP_LE);
    endfunction

    function automatic logic pick(input logic [2:0] o,
                                  input logic lt, input logic eq);
        logic r;
        case (o)
            OP_EQ:          r = eq;
            OP_LT, OP_LTU:  r = lt;
            OP_LE, OP_LEU:  r = lt | eq;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Signed order of the top slice equals unsigned order with MSB flipped.
    always_comb begin
        sa = SLICE'(a_q >> (32'(idx_q) * SLICE));
        sb = SLICE'(b_q >> (32'(idx_q) * SLICE));
        if (op_signed(op_q) && (idx_q == TOP)) begin
            sa[SLICE-1] = ~sa[SLICE-1];
            sb[SLICE-1] = ~sb[SLICE-1];
        end
        slice_lt = (sa < sb);
        slice_eq = (sa == sb);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    idx_d   = TOP;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // reserved ops take one pass here so k=1 holds for them too
                if (!op_valid(op_q)) begin
                    res_d   = 1'b0;
                    state_d = DONE;
                end else if (!slice_eq) begin
                    res_d   = pick(op_q, slice_lt, 1'b0);
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = pick(op_q, 1'b0, 1'b1);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.y         = {{(WIDTH-1){1'b0}}, res_q};
endmodule
